// File: rtl/voice_pkg.sv
// Shared constants and types for the voice allocator.
package voice_pkg;

    // Word addresses: byte address bits [7:2].
    localparam logic [5:0] ADDR_CTRL       = 6'h00;
    localparam logic [5:0] ADDR_STATUS     = 6'h01;
    localparam logic [5:0] ADDR_CMD        = 6'h02;
    localparam logic [5:0] ADDR_VOICE_BASE = 6'h04;

    // Voice-stealing policies. Encoding 3 behaves as none.
    localparam logic [1:0] POL_NONE     = 2'd0;
    localparam logic [1:0] POL_OLDEST   = 2'd1;
    localparam logic [1:0] POL_QUIETEST = 2'd2;

    localparam logic [31:0] RD_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StCommit
    } state_e;

endpackage

// File: rtl/voice_select.sv
// Sequential scan comparator: sees one voice per step and keeps the
// lowest-index note match, the lowest-index free voice and the steal victim.
module voice_select
    import voice_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned NOTE_W     = 7,
    parameter int unsigned VEL_W      = 7,
    parameter int unsigned AGE_W      = 8,
    localparam int unsigned IDX_W     = $clog2(NUM_VOICES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic [IDX_W-1:0]  idx,
    input  logic              active,
    input  logic [NOTE_W-1:0] note,
    input  logic [VEL_W-1:0]  vel,
    input  logic [AGE_W-1:0]  age,
    input  logic [NOTE_W-1:0] key,
    input  logic [1:0]        policy,
    output logic              match_valid,
    output logic [IDX_W-1:0]  match_idx,
    output logic              free_valid,
    output logic [IDX_W-1:0]  free_idx,
    output logic              victim_valid,
    output logic [IDX_W-1:0]  victim_idx
);

    logic             match_valid_q, match_valid_d;
    logic [IDX_W-1:0] match_idx_q, match_idx_d;
    logic             free_valid_q, free_valid_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic             victim_valid_q, victim_valid_d;
    logic [IDX_W-1:0] victim_idx_q, victim_idx_d;
    logic [AGE_W-1:0] victim_age_q, victim_age_d;
    logic [VEL_W-1:0] victim_vel_q, victim_vel_d;
    logic             better;

    // Candidate update; strict comparisons keep ties on the lowest index.
    always_comb begin
        match_valid_d  = match_valid_q;
        match_idx_d    = match_idx_q;
        free_valid_d   = free_valid_q;
        free_idx_d     = free_idx_q;
        victim_valid_d = victim_valid_q;
        victim_idx_d   = victim_idx_q;
        victim_age_d   = victim_age_q;
        victim_vel_d   = victim_vel_q;
        better = !victim_valid_q ||
                 (policy == POL_OLDEST   && age > victim_age_q) ||
                 (policy == POL_QUIETEST && vel < victim_vel_q);
        if (start) begin
            match_valid_d  = 1'b0;
            match_idx_d    = '0;
            free_valid_d   = 1'b0;
            free_idx_d     = '0;
            victim_valid_d = 1'b0;
            victim_idx_d   = '0;
            victim_age_d   = '0;
            victim_vel_d   = '0;
        end else if (step) begin
            if (active && note == key && !match_valid_q) begin
                match_valid_d = 1'b1;
                match_idx_d   = idx;
            end
            if (!active && !free_valid_q) begin
                free_valid_d = 1'b1;
                free_idx_d   = idx;
            end
            if (active && better) begin
                victim_valid_d = 1'b1;
                victim_idx_d   = idx;
                victim_age_d   = age;
                victim_vel_d   = vel;
            end
        end
    end

    // Candidate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_valid_q  <= 1'b0;
            match_idx_q    <= '0;
            free_valid_q   <= 1'b0;
            free_idx_q     <= '0;
            victim_valid_q <= 1'b0;
            victim_idx_q   <= '0;
            victim_age_q   <= '0;
            victim_vel_q   <= '0;
        end else begin
            match_valid_q  <= match_valid_d;
            match_idx_q    <= match_idx_d;
            free_valid_q   <= free_valid_d;
            free_idx_q     <= free_idx_d;
            victim_valid_q <= victim_valid_d;
            victim_idx_q   <= victim_idx_d;
            victim_age_q   <= victim_age_d;
            victim_vel_q   <= victim_vel_d;
        end
    end

    assign match_valid  = match_valid_q;
    assign match_idx    = match_idx_q;
    assign free_valid   = free_valid_q;
    assign free_idx     = free_idx_q;
    assign victim_valid = victim_valid_q;
    assign victim_idx   = victim_idx_q;

endmodule

// File: rtl/voice_allocator.sv
// Wishbone-controlled voice allocator: note-on/off commands are scanned
// against all voices and committed to one channel with retrigger and stealing.
module voice_allocator
    import voice_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned NOTE_W     = 7,
    parameter int unsigned VEL_W      = 7,
    parameter int unsigned AGE_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic [31:0]                  wb_adr_i,
    input  logic [31:0]                  wb_dat_i,
    output logic [31:0]                  wb_dat_o,
    output logic                         wb_ack_o,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*VEL_W-1:0]  voice_vel,
    output logic                         irq
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d, rd_data;
    logic                  enable_q, enable_d, retrig_q, retrig_d, irq_en_q, irq_en_d;
    logic [1:0]            policy_q, policy_d;
    logic                  drop_q, drop_d, ovf_q, ovf_d, drop_set;
    state_e                state_q, state_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d, tgt;
    logic [NOTE_W-1:0]     cmd_note_q, cmd_note_d;
    logic [VEL_W-1:0]      cmd_vel_q, cmd_vel_d;
    logic                  cmd_on_q, cmd_on_d;
    // Gate and active always move together, so one register drives both.
    logic [NUM_VOICES-1:0] active_q, active_d, trig_q, trig_d;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d [NUM_VOICES];
    logic [VEL_W-1:0]      vel_q  [NUM_VOICES];
    logic [VEL_W-1:0]      vel_d  [NUM_VOICES];
    logic [AGE_W-1:0]      age_q  [NUM_VOICES];
    logic [AGE_W-1:0]      age_d  [NUM_VOICES];
    logic                  access, wr, rd, cmd_wr, busy, hit, sel_start, sel_step;
    logic [5:0]            addr, count;
    logic                  match_valid, free_valid, victim_valid;
    logic [IDX_W-1:0]      match_idx, free_idx, victim_idx;
    logic                  unused_bits;

    assign access = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr     = access & wb_we_i;
    assign rd     = access & ~wb_we_i;
    assign addr   = wb_adr_i[7:2];
    assign cmd_wr = wr && addr == ADDR_CMD;
    assign busy   = state_q != StIdle;
    assign unused_bits = ^{wb_adr_i, wb_dat_i, count[5]};

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .NOTE_W     (NOTE_W),
        .VEL_W      (VEL_W),
        .AGE_W      (AGE_W)
    ) u_select (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (sel_start),
        .step         (sel_step),
        .idx          (scan_idx_q),
        .active       (active_q[scan_idx_q]),
        .note         (note_q[scan_idx_q]),
        .vel          (vel_q[scan_idx_q]),
        .age          (age_q[scan_idx_q]),
        .key          (cmd_note_q),
        .policy       (policy_q),
        .match_valid  (match_valid),
        .match_idx    (match_idx),
        .free_valid   (free_valid),
        .free_idx     (free_idx),
        .victim_valid (victim_valid),
        .victim_idx   (victim_idx)
    );

    // Active-voice popcount and read-data mux.
    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_VOICES; i++) count = count + 6'(active_q[i]);
        rd_data = RD_DEFAULT;
        if (addr == ADDR_CTRL) begin
            rd_data = {27'b0, irq_en_q, retrig_q, policy_q, enable_q};
        end else if (addr == ADDR_STATUS) begin
            rd_data = {busy, drop_q, ovf_q, count[4:0], 24'(active_q)};
        end else if (addr == ADDR_CMD) begin
            rd_data = '0;
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (addr == 6'(int'(ADDR_VOICE_BASE) + i)) begin
                rd_data = {8'(age_q[i]), 6'b0, active_q[i], active_q[i],
                           8'(vel_q[i]), 8'(note_q[i])};
            end
        end
    end

    // Allocation FSM and per-voice next state.
    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        cmd_note_d = cmd_note_q;
        cmd_vel_d  = cmd_vel_q;
        cmd_on_d   = cmd_on_q;
        active_d   = active_q;
        note_d     = note_q;
        vel_d      = vel_q;
        age_d      = age_q;
        trig_d     = '0;
        sel_start  = 1'b0;
        sel_step   = 1'b0;
        drop_set   = 1'b0;
        hit        = 1'b0;
        tgt        = '0;
        if (!enable_q) begin
            // Disabled: abort any command and release every voice.
            state_d  = StIdle;
            active_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_wr) begin
                        state_d    = StScan;
                        scan_idx_d = '0;
                        cmd_note_d = wb_dat_i[NOTE_W-1:0];
                        cmd_vel_d  = wb_dat_i[8 +: VEL_W];
                        cmd_on_d   = wb_dat_i[16];
                        sel_start  = 1'b1;
                    end
                end
                StScan: begin
                    sel_step = 1'b1;
                    if (scan_idx_q == IDX_W'(NUM_VOICES - 1)) state_d = StCommit;
                    else scan_idx_d = scan_idx_q + IDX_W'(1);
                end
                StCommit: begin
                    state_d = StIdle;
                    if (cmd_on_q) begin
                        hit = 1'b1;
                        if (retrig_q && match_valid) tgt = match_idx;
                        else if (free_valid) tgt = free_idx;
                        else if ((policy_q == POL_OLDEST || policy_q == POL_QUIETEST) &&
                                 victim_valid) tgt = victim_idx;
                        else hit = 1'b0;
                        if (hit) begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (active_q[i] && age_q[i] != '1) age_d[i] = age_q[i] + AGE_W'(1);
                            end
                            note_d[tgt]   = cmd_note_q;
                            vel_d[tgt]    = cmd_vel_q;
                            age_d[tgt]    = '0;
                            active_d[tgt] = 1'b1;
                            trig_d[tgt]   = 1'b1;
                        end else begin
                            drop_set = 1'b1;
                        end
                    end else if (match_valid) begin
                        active_d[match_idx] = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Bus handshake, control register writes and sticky status flags.
    always_comb begin
        ack_d    = access;
        dat_d    = rd ? rd_data : dat_q;
        enable_d = enable_q;
        policy_d = policy_q;
        retrig_d = retrig_q;
        irq_en_d = irq_en_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        if (wr && addr == ADDR_CTRL) begin
            enable_d = wb_dat_i[0];
            policy_d = wb_dat_i[2:1];
            retrig_d = wb_dat_i[3];
            irq_en_d = wb_dat_i[4];
        end
        if (wr && addr == ADDR_STATUS) begin
            drop_d = 1'b0;
            ovf_d  = 1'b0;
        end
        if (drop_set) drop_d = 1'b1;
        if (cmd_wr && (busy || !enable_q)) ovf_d = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            enable_q   <= 1'b1;
            policy_q   <= POL_NONE;
            retrig_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            drop_q     <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= StIdle;
            scan_idx_q <= '0;
            cmd_note_q <= '0;
            cmd_vel_q  <= '0;
            cmd_on_q   <= 1'b0;
            active_q   <= '0;
            trig_q     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            enable_q   <= enable_d;
            policy_q   <= policy_d;
            retrig_q   <= retrig_d;
            irq_en_q   <= irq_en_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            cmd_note_q <= cmd_note_d;
            cmd_vel_q  <= cmd_vel_d;
            cmd_on_q   <= cmd_on_d;
            active_q   <= active_d;
            trig_q     <= trig_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            age_q      <= age_d;
        end
    end

    // Flatten per-voice note and velocity onto the output buses.
    always_comb begin
        voice_note = '0;
        voice_vel  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[i*NOTE_W +: NOTE_W] = note_q[i];
            voice_vel[i*VEL_W +: VEL_W]    = vel_q[i];
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign voice_gate = active_q;
    assign voice_trig = trig_q;
    assign irq        = drop_q & irq_en_q;

endmodule
